fifo_push_arbiter: RTL and testbench

Shares the single push port of the byte-wide TX FIFO between two sensor result producers: requester A (DHT, temperature/humidity word) and requester B (SR04, distance word). Each accepted 16-bit result is serialised into an atomic 3-byte frame (tag, high byte, low byte) and pushed only while the FIFO reports not-full. Arbitration between the two producers is round-robin. The block sits between the sensor controllers and the FIFO write side in the top-level sensor/UART design.

---
 rtl/fifo_push_arbiter_pkg.sv | 30 +++
 rtl/fifo_push_arbiter_rr_arbiter_2.sv | 17 +
 rtl/fifo_push_arbiter.sv | 97 +++++++++
 tb/tb_fifo_push_arbiter.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/fifo_push_arbiter_pkg.sv
// Shared types and constants for the two-producer FIFO push arbiter.
// Frames are three bytes long: a tag byte, then the high and low bytes of the result word.
package fifo_push_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TAG  = 2'd1,
    HI   = 2'd2,
    LO   = 2'd3
  } state_t;

  typedef enum logic {
    GRANT_A = 1'b0,
    GRANT_B = 1'b1
  } grant_t;

  localparam logic [7:0] DEFAULT_TAG_A = 8'h44;
  localparam logic [7:0] DEFAULT_TAG_B = 8'h53;
  localparam int unsigned FRAME_LEN = 3;

  // Successor of a frame state once its byte has been pushed.
  function automatic state_t next_frame_state(input state_t s);
    case (s)
      TAG:     return HI;
      HI:      return LO;
      default: return IDLE;
    endcase
  endfunction

endpackage

// File: rtl/fifo_push_arbiter_rr_arbiter_2.sv
// Two-way round-robin arbiter: a lone request wins outright, and a tie goes to the side
// that was not granted last. The grant is one-hot and is suppressed when en is low.
module rr_arbiter_2
  import fifo_push_arbiter_pkg::*;
(
  input  logic   req_a,
  input  logic   req_b,
  input  grant_t last_grant,
  input  logic   en,
  output logic   gnt_a,
  output logic   gnt_b
);

  assign gnt_a = en && req_a && (!req_b || (last_grant == GRANT_B));
  assign gnt_b = en && req_b && (!req_a || (last_grant == GRANT_A));

endmodule

// File: rtl/fifo_push_arbiter.sv
// Arbitrates two sensor producers onto the TX FIFO push port. Each granted 16-bit word
// is emitted as an atomic tag/high/low frame, and every push is throttled by fifo_full.
module fifo_push_arbiter
  import fifo_push_arbiter_pkg::*;
#(
  parameter logic [7:0] TAG_A = DEFAULT_TAG_A,
  parameter logic [7:0] TAG_B = DEFAULT_TAG_B
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_a,
  input  logic [15:0] data_a,
  output logic        ack_a,
  input  logic        req_b,
  input  logic [15:0] data_b,
  output logic        ack_b,
  input  logic        fifo_full,
  output logic        fifo_push,
  output logic [7:0]  fifo_push_data,
  output logic        busy
);

  state_t      state;
  grant_t      last_grant;
  logic [15:0] word;
  logic [7:0]  tag;
  logic        gnt_a;
  logic        gnt_b;

  // Gating the enable with rst keeps both acks low for as long as reset is held.
  rr_arbiter_2 u_arb (
    .req_a      (req_a),
    .req_b      (req_b),
    .last_grant (last_grant),
    .en         ((state == IDLE) && rst),
    .gnt_a      (gnt_a),
    .gnt_b      (gnt_b)
  );

  assign ack_a = gnt_a;
  assign ack_b = gnt_b;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      last_grant <= GRANT_B;
      word       <= 16'h0000;
      tag        <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_a) begin
            word       <= data_a;
            tag        <= TAG_A;
            last_grant <= GRANT_A;
            state      <= TAG;
          end else if (gnt_b) begin
            word       <= data_b;
            tag        <= TAG_B;
            last_grant <= GRANT_B;
            state      <= TAG;
          end
        end
        default: begin
          // A full FIFO freezes the frame in place so no byte is skipped or repeated.
          if (!fifo_full) state <= next_frame_state(state);
        end
      endcase
    end
  end

  always_comb begin
    fifo_push      = 1'b0;
    fifo_push_data = 8'h00;
    case (state)
      TAG: begin
        fifo_push      = !fifo_full;
        fifo_push_data = tag;
      end
      HI: begin
        fifo_push      = !fifo_full;
        fifo_push_data = word[15:8];
      end
      LO: begin
        fifo_push      = !fifo_full;
        fifo_push_data = word[7:0];
      end
      default: begin
        fifo_push      = 1'b0;
        fifo_push_data = 8'h00;
      end
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Self-checking bench for fifo_push_arbiter: a queue-based frame model is compared every
// cycle, and directed scenarios pin the pushed byte streams to hand-computed values.
module tb_fifo_push_arbiter;

  localparam logic [7:0] TAG_A = 8'h44;
  localparam logic [7:0] TAG_B = 8'h53;

  logic        clk;
  logic        rst;
  logic        req_a;
  logic [15:0] data_a;
  logic        ack_a;
  logic        req_b;
  logic [15:0] data_b;
  logic        ack_b;
  logic        fifo_full;
  logic        fifo_push;
  logic [7:0]  fifo_push_data;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [7:0] push_log[$];
  int         ack_b_count = 0;
  int         busy_cycles = 0;

  // Model state: bytes of the frame still to be pushed, and who won the last grant.
  logic [7:0] model_q[$];
  logic       model_last_b = 1'b1;

  fifo_push_arbiter dut (
    .clk            (clk),
    .rst            (rst),
    .req_a          (req_a),
    .data_a         (data_a),
    .ack_a          (ack_a),
    .req_b          (req_b),
    .data_b         (data_b),
    .ack_b          (ack_b),
    .fifo_full      (fifo_full),
    .fifo_push      (fifo_push),
    .fifo_push_data (fifo_push_data),
    .busy           (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_output(input string name, input logic [15:0] actual,
                              input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic apply_stimulus(input logic r, input logic ra, input logic [15:0] da,
                                input logic rb, input logic [15:0] db, input logic full);
    rst       = r;
    req_a     = ra;
    data_a    = da;
    req_b     = rb;
    data_b    = db;
    fifo_full = full;
    @(posedge clk);
    #1;
  endtask

  task automatic check_log(input string name, input logic [7:0] expected[$]);
    check_output({name, " length"}, 16'(push_log.size()), 16'(expected.size()));
    for (int i = 0; i < expected.size() && i < push_log.size(); i++)
      check_output($sformatf("%s byte %0d", name, i), {8'h00, push_log[i]},
                   {8'h00, expected[i]});
  endtask

  // Per-cycle comparison against the frame-queue model, then model advance for the next edge.
  always @(negedge clk) begin
    logic       e_ack_a, e_ack_b, e_push, e_busy, win_a;
    logic [7:0] e_data;
    e_ack_a = 1'b0;
    e_ack_b = 1'b0;
    e_push  = 1'b0;
    e_busy  = 1'b0;
    e_data  = 8'h00;
    win_a   = 1'b0;
    if (rst && model_q.size() == 0 && (req_a || req_b)) begin
      if (req_a && req_b) win_a = model_last_b;
      else                win_a = req_a;
      e_ack_a = win_a;
      e_ack_b = !win_a;
    end
    if (rst && model_q.size() != 0) begin
      e_busy = 1'b1;
      e_push = !fifo_full;
      e_data = model_q[0];
    end
    check_output("ack_a", {15'd0, ack_a}, {15'd0, e_ack_a});
    check_output("ack_b", {15'd0, ack_b}, {15'd0, e_ack_b});
    check_output("fifo_push", {15'd0, fifo_push}, {15'd0, e_push});
    check_output("fifo_push_data", {8'd0, fifo_push_data}, {8'd0, e_data});
    check_output("busy", {15'd0, busy}, {15'd0, e_busy});

    if (fifo_push === 1'b1) push_log.push_back(fifo_push_data);
    if (ack_b === 1'b1) ack_b_count++;
    if (busy === 1'b1) busy_cycles++;

    if (!rst) begin
      model_q.delete();
      model_last_b = 1'b1;
    end else if (e_ack_a) begin
      model_q = '{TAG_A, data_a[15:8], data_a[7:0]};
      model_last_b = 1'b0;
    end else if (e_ack_b) begin
      model_q = '{TAG_B, data_b[15:8], data_b[7:0]};
      model_last_b = 1'b1;
    end else if (e_push) begin
      void'(model_q.pop_front());
    end
  end

  initial begin
    int guard;
    rst = 1'b0; req_a = 1'b1; req_b = 1'b1;
    data_a = 16'h1111; data_b = 16'h2222; fifo_full = 1'b0;

    // Reset held with both requests high.
    @(posedge clk); #1;
    @(negedge clk);
    check_output("reset push", {15'd0, fifo_push}, 16'd0);
    check_output("reset data", {8'd0, fifo_push_data}, 16'd0);
    check_output("reset ack_a", {15'd0, ack_a}, 16'd0);
    check_output("reset ack_b", {15'd0, ack_b}, 16'd0);
    check_output("reset busy", {15'd0, busy}, 16'd0);
    @(posedge clk); #1;

    // Single A frame, FIFO never full.
    push_log.delete(); busy_cycles = 0;
    apply_stimulus(1, 1, 16'h1234, 0, 16'h0000, 0);
    for (int c = 0; c < 5; c++) apply_stimulus(1, 0, 16'h1234, 0, 16'h0000, 0);
    check_log("single A", '{8'h44, 8'h12, 8'h34});
    check_output("single A busy cycles", 16'(busy_cycles), 16'd3);

    // Both requesting continuously from reset: strict alternation starting with A.
    apply_stimulus(0, 0, 16'h0000, 0, 16'h0000, 0);
    push_log.delete();
    guard = 0;
    do begin
      apply_stimulus(1, 1, 16'hAAAA, 1, 16'h0BCD, 0);
      guard++;
    end while (push_log.size() < 12 && guard < 100);
    check_output("alternation within budget", {15'd0, guard < 100}, 16'd1);
    for (int c = 0; c < 3; c++) apply_stimulus(1, 0, 16'h0000, 0, 16'h0000, 0);
    check_log("alternation", '{8'h44, 8'hAA, 8'hAA, 8'h53, 8'h0B, 8'hCD,
                               8'h44, 8'hAA, 8'hAA, 8'h53, 8'h0B, 8'hCD});

    // Back-pressure for three cycles starting in the HI cycle.
    push_log.delete(); busy_cycles = 0;
    for (int c = 0; c < 9; c++)
      apply_stimulus(1, c == 0, 16'h1234, 0, 16'h0000, (c >= 2 && c <= 4));
    check_log("backpressure", '{8'h44, 8'h12, 8'h34});
    check_output("backpressure busy cycles", 16'(busy_cycles), 16'd6);

    // Reset right after the TAG push of a B frame, then an A frame.
    push_log.delete();
    apply_stimulus(1, 0, 16'h0000, 1, 16'hBEEF, 0);
    apply_stimulus(1, 0, 16'h0000, 0, 16'hBEEF, 0);
    rst = 1'b0; req_a = 1'b1; data_a = 16'h5678;
    @(negedge clk);
    check_output("midreset busy", {15'd0, busy}, 16'd0);
    check_output("midreset push", {15'd0, fifo_push}, 16'd0);
    check_output("midreset data", {8'd0, fifo_push_data}, 16'd0);
    check_output("midreset ack_a", {15'd0, ack_a}, 16'd0);
    @(posedge clk); #1;
    apply_stimulus(0, 1, 16'h5678, 0, 16'h0000, 0);
    apply_stimulus(1, 1, 16'h5678, 0, 16'h0000, 0);
    for (int c = 0; c < 5; c++) apply_stimulus(1, 0, 16'h5678, 0, 16'h0000, 0);
    check_log("midreset", '{8'h53, 8'h44, 8'h56, 8'h78});

    // One-cycle B pulse yields exactly one frame and one ack.
    push_log.delete(); ack_b_count = 0;
    apply_stimulus(1, 0, 16'h0000, 1, 16'h00FF, 0);
    for (int c = 0; c < 8; c++) apply_stimulus(1, 0, 16'h0000, 0, 16'h00FF, 0);
    check_log("pulse B", '{8'h53, 8'h00, 8'hFF});
    check_output("pulse B ack count", 16'(ack_b_count), 16'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
